// File: rtl/oka_split_issue.sv
// Karatsuba operand splitter: latches an operand pair and issues the even, odd
// and GF(2) sum sub-operand pairs to a downstream sub-multiplier, one per handshake.
module oka_split_issue #(
    parameter int unsigned n = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [n-1:0]     A_in,
    input  logic [n-1:0]     B_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [n/2-1:0]   S_a,
    output logic [n/2-1:0]   S_b,
    output logic [1:0]       S_tag,
    output logic             S_last
);

    localparam int unsigned h = n / 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_E = 2'd1,
        ISSUE_O = 2'd2,
        ISSUE_S = 2'd3
    } state_t;

    state_t         state;
    logic [n-1:0]   a_reg;
    logic [n-1:0]   b_reg;
    logic [h-1:0]   a_even, a_odd, b_even, b_odd;
    logic           in_hs;
    logic           out_hs;

    // Overlap-free split: even coefficients to one half, odd to the other.
    always_comb begin
        a_even = '0;
        a_odd  = '0;
        b_even = '0;
        b_odd  = '0;
        for (int unsigned i = 0; i < h; i++) begin
            a_even[i] = a_reg[2*i];
            a_odd[i]  = a_reg[2*i+1];
            b_even[i] = b_reg[2*i];
            b_odd[i]  = b_reg[2*i+1];
        end
    end

    // Handshake outputs are gated by rst_n so they read idle throughout reset.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                ISSUE_S: in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign out_valid = rst_n && (state != IDLE);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_comb begin
        S_a    = '0;
        S_b    = '0;
        S_tag  = 2'b00;
        S_last = 1'b0;
        if (out_valid) begin
            case (state)
                ISSUE_E: begin
                    S_a   = a_even;
                    S_b   = b_even;
                    S_tag = 2'b00;
                end
                ISSUE_O: begin
                    S_a   = a_odd;
                    S_b   = b_odd;
                    S_tag = 2'b01;
                end
                ISSUE_S: begin
                    S_a    = a_even ^ a_odd;
                    S_b    = b_even ^ b_odd;
                    S_tag  = 2'b10;
                    S_last = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (in_hs) begin
                a_reg <= A_in;
                b_reg <= B_in;
            end
            case (state)
                IDLE:    if (in_hs)  state <= ISSUE_E;
                ISSUE_E: if (out_hs) state <= ISSUE_O;
                ISSUE_O: if (out_hs) state <= ISSUE_S;
                ISSUE_S: if (out_hs) state <= in_hs ? ISSUE_E : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oka_split_issue.sv
// Directed self-checking bench for oka_split_issue with n = 8.
module tb_oka_split_issue;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A_in;
    logic [7:0] B_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] S_a;
    logic [3:0] S_b;
    logic [1:0] S_tag;
    logic       S_last;

    int checks;
    int failures;

    oka_split_issue #(.n(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_in      (A_in),
        .B_in      (B_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S_a       (S_a),
        .S_b       (S_b),
        .S_tag     (S_tag),
        .S_last    (S_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_pair(input string tag, input logic [3:0] a, input logic [3:0] b,
                              input logic [1:0] t, input logic l);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".S_a"},   32'(S_a),       32'(a));
        check({tag, ".S_b"},   32'(S_b),       32'(b));
        check({tag, ".S_tag"}, 32'(S_tag),     32'(t));
        check({tag, ".S_last"},32'(S_last),    32'(l));
    endtask

    task automatic check_idle_out(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".S_a"},   32'(S_a),       32'd0);
        check({tag, ".S_b"},   32'(S_b),       32'd0);
        check({tag, ".S_tag"}, 32'(S_tag),     32'd0);
        check({tag, ".S_last"},32'(S_last),    32'd0);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        A_in     = a;
        B_in     = b;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A_in      = 8'h00;
        B_in      = 8'h00;

        step;
        step;
        check_idle_out("rst");
        check("rst.in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel.in_ready", 32'(in_ready), 32'd1);

        // Basic split
        offer(8'hB5, 8'h3C);
        step;
        in_valid = 1'b0;
        check_pair("b.e", 4'h7, 4'h6, 2'b00, 1'b0);
        check("b.e.in_ready", 32'(in_ready), 32'd0);
        step;
        check_pair("b.o", 4'hC, 4'h6, 2'b01, 1'b0);
        step;
        check_pair("b.s", 4'hB, 4'h0, 2'b10, 1'b1);
        check("b.s.in_ready", 32'(in_ready), 32'd1);
        step;
        check_idle_out("b.idle");
        check("b.idle.in_ready", 32'(in_ready), 32'd1);

        // Backpressure in ISSUE_O
        offer(8'hB5, 8'h3C);
        step;
        in_valid = 1'b0;
        check_pair("bp.e", 4'h7, 4'h6, 2'b00, 1'b0);
        step;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_pair("bp.hold", 4'hC, 4'h6, 2'b01, 1'b0);
            step;
        end
        out_ready = 1'b1;
        #1;
        check_pair("bp.o", 4'hC, 4'h6, 2'b01, 1'b0);
        step;
        check_pair("bp.s", 4'hB, 4'h0, 2'b10, 1'b1);
        step;
        check_idle_out("bp.idle");

        // Back-to-back with in_valid held
        offer(8'hFF, 8'h01);
        step;
        A_in = 8'h00;
        B_in = 8'hAA;
        check_pair("bb.e1", 4'hF, 4'h1, 2'b00, 1'b0);
        step;
        check_pair("bb.o1", 4'hF, 4'h0, 2'b01, 1'b0);
        step;
        check_pair("bb.s1", 4'h0, 4'h1, 2'b10, 1'b1);
        check("bb.s1.in_ready", 32'(in_ready), 32'd1);
        step;
        in_valid = 1'b0;
        check_pair("bb.e2", 4'h0, 4'h0, 2'b00, 1'b0);
        step;
        check_pair("bb.o2", 4'h0, 4'hF, 2'b01, 1'b0);
        step;
        check_pair("bb.s2", 4'h0, 4'hF, 2'b10, 1'b1);
        step;
        check_idle_out("bb.idle");

        // Reset during ISSUE_O
        offer(8'hB5, 8'h3C);
        step;
        in_valid = 1'b0;
        step;
        check_pair("rm.o", 4'hC, 4'h6, 2'b01, 1'b0);
        rst_n = 1'b0;
        #1;
        check_idle_out("rm.inrst");
        check("rm.inrst.in_ready", 32'(in_ready), 32'd0);
        step;
        rst_n = 1'b1;
        #1;
        check_idle_out("rm.after");
        check("rm.after.in_ready", 32'(in_ready), 32'd1);
        step;
        check_idle_out("rm.idle");

        // Input offered while busy is ignored
        offer(8'hB5, 8'h3C);
        step;
        offer(8'h12, 8'h34);
        check_pair("ig.e", 4'h7, 4'h6, 2'b00, 1'b0);
        check("ig.e.in_ready", 32'(in_ready), 32'd0);
        step;
        in_valid = 1'b0;
        check_pair("ig.o", 4'hC, 4'h6, 2'b01, 1'b0);
        step;
        check_pair("ig.s", 4'hB, 4'h0, 2'b10, 1'b1);
        step;
        check_idle_out("ig.idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
